bitbrick_shift_accumulator: RTL and testbench

- Downstream of the signed 3-bit BitBrick multiplier.
- Consumes a stream of 6-bit signed brick products, each tagged with a left-shift amount (2*(i+j) for brick positions i, j).
- Sign-extends, shifts and accumulates the products into a wide signed sum, one beat per cycle.
- Emits the fused result on a registered valid/ready output when the beat flagged last is accepted; this rebuilds a multi-bit (fused) product or dot product from 3-bit bricks.

---
 rtl/bitbrick_shift_accumulator.sv | 121 ++++++++++++
 tb/tb_bitbrick_shift_accumulator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbrick_shift_accumulator.sv
// Shift-and-accumulate stage behind the signed 3-bit BitBrick multiplier.
// Fuses a stream of shifted 6-bit brick products into one wide signed result per last beat.
module bitbrick_shift_accumulator #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_product,
    input  logic [3:0]       in_shift,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned PROD_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY,
        PARTIAL
    } state_e;

    state_e             state_q, state_d;
    logic               rst_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic               accept;
    logic               pop;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum;
    logic               ovf_now;
    logic [CNT_W-1:0]   cnt_inc;

    // Input only stalls while a finished result is still waiting for the consumer.
    assign in_ready = !rst_q && !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Sign-extend, shift (bits past ACC_W drop off) and add with wrap-around.
    always_comb begin
        prod_ext = {{(ACC_W - PROD_W){in_product[PROD_W-1]}}, in_product};
        term     = prod_ext << in_shift;
        base     = (state_q == PARTIAL) ? acc_q : '0;
        sum      = base + term;
        ovf_now  = (base[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !pop;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;

        if (accept) begin
            if (in_last) begin
                out_valid_d = 1'b1;
                out_data_d  = sum;
                out_ovf_d   = ovf_q || ovf_now;
                out_count_d = cnt_inc;
                acc_d       = '0;
                ovf_d       = 1'b0;
                cnt_d       = '0;
                state_d     = EMPTY;
            end else begin
                acc_d       = sum;
                ovf_d       = ovf_q || ovf_now;
                cnt_d       = cnt_inc;
                state_d     = PARTIAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            state_q     <= EMPTY;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            rst_q       <= 1'b0;
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_bitbrick_shift_accumulator.sv
// Bench for bitbrick_shift_accumulator: instance 0 is 32/8-bit, instance 1 is 16/4-bit.
// An arithmetic model of the fused-sum rules is checked against both instances every cycle.
module tb_bitbrick_shift_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [2];
    logic       in_valid   [2];
    logic [5:0] in_product [2];
    logic [3:0] in_shift   [2];
    logic       in_last    [2];
    logic       out_ready  [2];

    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic        out_ovf_a, out_ovf_b;
    logic [31:0] out_data_a;
    logic [15:0] out_data_b;
    logic [7:0]  out_count_a;
    logic [3:0]  out_count_b;

    bitbrick_shift_accumulator #(.ACC_W(32), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready_a),
        .in_product(in_product[0]), .in_shift(in_shift[0]), .in_last(in_last[0]),
        .out_valid(out_valid_a), .out_ready(out_ready[0]), .out_data(out_data_a),
        .out_ovf(out_ovf_a), .out_count(out_count_a)
    );

    bitbrick_shift_accumulator #(.ACC_W(16), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready_b),
        .in_product(in_product[1]), .in_shift(in_shift[1]), .in_last(in_last[1]),
        .out_valid(out_valid_b), .out_ready(out_ready[1]), .out_data(out_data_b),
        .out_ovf(out_ovf_b), .out_count(out_count_b)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference state: plain signed integers.
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_cnt [2];
    bit     m_ov  [2];
    longint m_od  [2];
    bit     m_oo  [2];
    int     m_oc  [2];
    bit     m_rstq[2];

    function automatic int width_of(int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 0) ? 255 : 15;
    endfunction

    // Reduce v modulo 2^w and read it back as a signed w-bit number.
    function automatic longint sx(longint v, int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic bit m_ready(int k);
        return !m_rstq[k] && !(m_ov[k] && !out_ready[k]);
    endfunction

    function automatic longint dut_data(int k);
        return (k == 0) ? sx(longint'(out_data_a), 32) : sx(longint'(out_data_b), 16);
    endfunction

    function automatic longint dut_count(int k);
        return (k == 0) ? longint'(out_count_a) : longint'(out_count_b);
    endfunction

    function automatic logic dut_valid(int k);
        return (k == 0) ? out_valid_a : out_valid_b;
    endfunction

    function automatic logic dut_ready(int k);
        return (k == 0) ? in_ready_a : in_ready_b;
    endfunction

    function automatic logic dut_ovf(int k);
        return (k == 0) ? out_ovf_a : out_ovf_b;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit     rdy;
        bit     acc_ok;
        bit     pop;
        longint term;
        longint exact;
        longint sum;
        bit     of;
        int     ncnt;
        if (rst[k]) begin
            m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
            m_ov[k] = 0; m_od[k] = 0; m_oo[k] = 0; m_oc[k] = 0;
            m_rstq[k] = 1;
        end else begin
            rdy    = m_ready(k);
            acc_ok = in_valid[k] && rdy;
            pop    = m_ov[k] && out_ready[k];
            if (pop) m_ov[k] = 0;
            if (acc_ok) begin
                term  = sx(longint'($signed(in_product[k])) << in_shift[k], width_of(k));
                exact = m_acc[k] + term;
                sum   = sx(exact, width_of(k));
                of    = (exact != sum);
                ncnt  = (m_cnt[k] + 1 > cmax_of(k)) ? cmax_of(k) : m_cnt[k] + 1;
                if (in_last[k]) begin
                    m_ov[k] = 1; m_od[k] = sum; m_oo[k] = m_ovf[k] | of; m_oc[k] = ncnt;
                    m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
                end else begin
                    m_acc[k] = sum; m_ovf[k] = m_ovf[k] | of; m_cnt[k] = ncnt;
                end
            end
            m_rstq[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cmp%0d in_ready", k), longint'(dut_ready(k)), longint'(m_ready(k)));
                chk($sformatf("cmp%0d out_valid", k), longint'(dut_valid(k)), longint'(m_ov[k]));
                if (m_ov[k]) begin
                    chk($sformatf("cmp%0d out_data", k), dut_data(k), m_od[k]);
                    chk($sformatf("cmp%0d out_ovf", k), longint'(dut_ovf(k)), longint'(m_oo[k]));
                    chk($sformatf("cmp%0d out_count", k), dut_count(k), longint'(m_oc[k]));
                end
            end
        end
    end

    // Hand-computed expectations, checked against both the DUT and the model.
    task automatic lit(input int k, input string name, input longint d, input longint c, input bit o);
        @(negedge clk);
        chk({name, " valid"}, longint'(dut_valid(k)), 1);
        chk({name, " data"}, dut_data(k), d);
        chk({name, " count"}, dut_count(k), c);
        chk({name, " ovf"}, longint'(dut_ovf(k)), longint'(o));
        chk({name, " model data"}, m_od[k], d);
        chk({name, " model count"}, longint'(m_oc[k]), c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until the accepting edge has passed.
    task automatic send(input int k, input int p, input int s, input bit last);
        bit ok;
        in_valid[k]   = 1'b1;
        in_product[k] = 6'(p);
        in_shift[k]   = 4'(s);
        in_last[k]    = last;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_ready(k)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) chk($sformatf("send%0d timeout", k), 0, 1);
        step();
    endtask

    task automatic idle(input int k);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; in_product[k] = '0;
            in_shift[k] = '0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
        end
        step();
        chk_en = 1'b1;
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset%0d in_ready", k), longint'(dut_ready(k)), 0);
            chk($sformatf("reset%0d out_valid", k), longint'(dut_valid(k)), 0);
            chk($sformatf("reset%0d out_data", k), dut_data(k), 0);
            chk($sformatf("reset%0d out_count", k), dut_count(k), 0);
            chk($sformatf("reset%0d out_ovf", k), longint'(dut_ovf(k)), 0);
        end
        step();

        send(0, 16, 12, 1); idle(0);
        lit(0, "single", 65536, 1, 0);
        step();

        send(0, 3, 0, 0); send(0, -4, 2, 0); send(0, -2, 4, 1); idle(0);
        lit(0, "fused", -45, 3, 0);
        step();

        out_ready[0] = 1'b0;
        send(0, 7, 0, 1);
        in_valid[0] = 1'b1; in_product[0] = 6'(9); in_shift[0] = 4'(1); in_last[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall in_ready", longint'(in_ready_a), 0);
            chk("stall out_data", dut_data(0), 7);
            step();
        end
        out_ready[0] = 1'b1;
        step();
        idle(0);
        lit(0, "nobubble", 18, 1, 0);
        step();

        send(0, 1, 0, 0); send(0, 2, 0, 0);
        rst[0] = 1'b1;
        in_valid[0] = 1'b1; in_product[0] = 6'(3); in_shift[0] = 4'(0); in_last[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst in_ready", longint'(in_ready_a), 0);
        chk("midrst out_valid", longint'(out_valid_a), 0);
        step();
        send(0, 5, 1, 1); idle(0);
        lit(0, "midrst", 10, 1, 0);
        step();

        send(1, 16, 10, 0); send(1, 16, 10, 1); idle(1);
        lit(1, "ovf", -32768, 2, 1);
        step();
        send(1, 1, 0, 1); idle(1);
        lit(1, "ovf_clear", 1, 1, 0);
        step();

        for (int i = 0; i < 20; i++) send(1, 1, 0, i == 19);
        idle(1);
        lit(1, "saturate", 20, 15, 0);
        step();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k]        = ($urandom % 300) == 0;
                in_valid[k]   = ($urandom % 4) != 0;
                in_product[k] = 6'($urandom);
                in_shift[k]   = 4'($urandom);
                in_last[k]    = ($urandom % ((cyc < 2000) ? 4 : 40)) == 0;
                out_ready[k]  = ($urandom % 4) != 0;
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            idle(k);
        end
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
